// File: rtl/ahb_pkg.sv
`timescale 1ns/1ps
// Shared AHB-Lite types and constants for the SRAM slave and its strobe generator.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // RISC-V "addi x0, x0, 0", used to fill memory not covered by the image.
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/ahb_strobe_gen.sv
`timescale 1ns/1ps
// Byte-lane strobes for an AHB access from the address low bits and HSIZE.
// Strobes are always aligned and clamped to the bus width; misalign/oversize are reported separately.
module ahb_strobe_gen
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int BW        = $clog2(NB)
) (
    input  logic [BW-1:0] addr,
    input  logic [2:0]    size,
    output logic [NB-1:0] strobe,
    output logic          misalign,
    output logic          oversize
);

    logic [2:0]    eff_size;
    logic [BW-1:0] align_mask;
    logic [BW-1:0] base;

    // NOTE: every output of this block is assigned before any condition, so no latch is inferred.
    always_comb begin
        oversize   = (size > 3'(BW));
        eff_size   = oversize ? 3'(BW) : size;
        align_mask = BW'((1 << eff_size) - 1);
        misalign   = |(addr & align_mask);
        base       = addr & ~align_mask;
        for (int i = 0; i < NB; i++) begin
            strobe[i] = (i >= int'(base)) && (i < int'(base) + (1 << eff_size));
        end
    end

endmodule

// File: rtl/ahb_sram_slave_wait.sv
`timescale 1ns/1ps
// AHB-Lite SRAM slave with WAIT_STATES wait cycles per data phase, preloaded from INIT_IMAGE.
// Define AHB_SLV_ERR_RESP_EN to enable ERROR responses; otherwise addresses wrap and accesses align.
module ahb_sram_slave_wait
    import ahb_pkg::*;
#(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     MEM_BYTES   = 1024,
    parameter int                     WAIT_STATES = 2,
    parameter int                     INIT_WORDS  = 0,
    parameter logic [MEM_BYTES*8-1:0] INIT_IMAGE  = '0,
    parameter logic [31:0]            FILL_WORD   = NOP_WORD
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [31:0]           num_instr,
    output logic                  inst_loaded
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int BW        = $clog2(NB);
    localparam int AW        = $clog2(MEM_BYTES);
    localparam int IW        = AW - BW;
    localparam int MEM_WORDS = MEM_BYTES / NB;

    typedef logic [MEM_WORDS-1:0][DATA_WIDTH-1:0] mem_t;

    // Image words are little-endian 32-bit words from byte 0; the rest is FILL_WORD.
    function automatic mem_t init_mem();
        logic [MEM_BYTES*8-1:0] flat;
        for (int k = 0; k < MEM_BYTES / 4; k++) begin
            flat[k*32 +: 32] = (k < INIT_WORDS) ? INIT_IMAGE[k*32 +: 32] : FILL_WORD;
        end
        return mem_t'(flat);
    endfunction

    mem_t mem = init_mem();

    assign num_instr   = 32'(INIT_WORDS);
    assign inst_loaded = 1'b1;

    slv_state_t            state;
    logic [3:0]            wait_cnt;
    logic [IW-1:0]         idx_q;
    logic                  wr_q;
    logic [NB-1:0]         strb_q;

    logic [NB-1:0]         strobe;
    logic                  misalign;
    logic                  oversize;
    logic                  accept;
    logic                  err_req;
    logic                  commit;
    logic [IW-1:0]         addr_idx;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    ahb_strobe_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
        .addr     (HADDR[BW-1:0]),
        .size     (HSIZE),
        .strobe   (strobe),
        .misalign (misalign),
        .oversize (oversize)
    );

    assign addr_idx = HADDR[AW-1:BW];
    assign accept   = HSEL && HREADY && HREADYOUT &&
                      (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

`ifdef AHB_SLV_ERR_RESP_EN
    assign err_req = (HADDR[31:AW] != '0) || misalign || oversize;
`else
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:AW], misalign, oversize};
    assign err_req     = 1'b0;
`endif

    assign commit = (state == ST_DATA) && wr_q;

    // The word being written this edge is forwarded so a back-to-back read sees the new data.
    assign rd_idx = (state == ST_WAIT) ? idx_q : addr_idx;
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            strb_q    <= '0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        HRDATA    <= rd_word;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end with HREADYOUT high, so a new address phase may start.
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    if (accept) begin
                        idx_q  <= addr_idx;
                        wr_q   <= HWRITE && !err_req;
                        strb_q <= strobe;
                        if (err_req) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            HREADYOUT <= 1'b0;
                            wait_cnt  <= 4'(WAIT_STATES - 1);
                        end else begin
                            state  <= ST_DATA;
                            HRDATA <= rd_word;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the memory array has no reset, so its contents and the preload survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave_wait.sv
`timescale 1ns/1ps
// Directed bench: DUT 0 uses 2 wait states (vector table), DUT 1 uses 0 (back-to-back sequence).
// Expectations follow AHB_SLV_ERR_RESP_EN when it is defined for the build.
module tb_ahb_sram_slave_wait;
    import ahb_pkg::*;

    localparam logic [8191:0] IMAGE = 8192'({32'h0020_0193, 32'h0010_0113, 32'h0000_0093});

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel        [2];
    logic [31:0] haddr       [2];
    logic [1:0]  htrans      [2];
    logic        hwrite      [2];
    logic [2:0]  hsize       [2];
    logic [31:0] hwdata      [2];
    logic        hreadyout   [2];
    logic [1:0]  hresp       [2];
    logic [31:0] hrdata      [2];
    logic [31:0] num_instr   [2];
    logic        inst_loaded [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_wait #(
        .DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(2),
        .INIT_WORDS(3), .INIT_IMAGE(IMAGE), .FILL_WORD(NOP_WORD)
    ) u_dut_w2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
        .num_instr(num_instr[0]), .inst_loaded(inst_loaded[0])
    );

    ahb_sram_slave_wait #(
        .DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(0),
        .INIT_WORDS(3), .INIT_IMAGE(IMAGE), .FILL_WORD(NOP_WORD)
    ) u_dut_w0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .num_instr(num_instr[1]), .inst_loaded(inst_loaded[1])
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                                logic [31:0] exp_rdata, logic [1:0] exp_resp);
        vec_t v;
        v.wr        = wr;
        v.addr      = addr;
        v.size      = size;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_resp  = exp_resp;
        v.exp_waits = (exp_resp == HRESP_ERROR) ? 1 : 2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = HTRANS_IDLE;
        haddr[d]  = '0;
        hwrite[d] = 1'b0;
        hsize[d]  = HSIZE_WORD;
    endtask

    // One NONSEQ transfer followed by IDLE; returns data-phase observations.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [1:0] first_resp, output logic [1:0] last_resp, output int waits);
        @(negedge clk);
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        haddr[d]  = addr;
        hwrite[d] = wr;
        hsize[d]  = size;
        @(negedge clk);
        drive_idle(d);
        hwdata[d]  = wdata;
        first_resp = hresp[d];
        waits      = 0;
        while (hreadyout[d] !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        rdata     = hrdata[d];
        last_resp = hresp[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic [1:0]  r_first, r_last;
        int          waits;
        int          lows;

        // Vectors applied to the 2-wait-state DUT; memory effects carry from row to row.
        vecs.push_back(mk(0, 32'h000, HSIZE_WORD, 32'h0, 32'h0000_0093, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h00C, HSIZE_WORD, 32'h0, 32'h0000_0013, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h010, HSIZE_WORD, 32'hDEAD_BEEF, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h010, HSIZE_WORD, 32'h0, 32'hDEAD_BEEF, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h010, HSIZE_WORD, 32'h1122_3344, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h013, HSIZE_BYTE, 32'hAA5A_5A5A, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h010, HSIZE_WORD, 32'h0, 32'hAA22_3344, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h012, HSIZE_HALF, 32'hBEEF_7777, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h010, HSIZE_WORD, 32'h0, 32'hBEEF_3344, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h014, HSIZE_BYTE, 32'h5A5A_5AA5, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h016, HSIZE_HALF, 32'h5678_1234, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h015, HSIZE_BYTE, 32'h0, 32'h5678_00A5, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h008, HSIZE_WORD, 32'h0, 32'h0020_0193, HRESP_OKAY));
`ifdef AHB_SLV_ERR_RESP_EN
        vecs.push_back(mk(0, 32'h400, HSIZE_WORD, 32'h0, 32'h0, HRESP_ERROR));
        vecs.push_back(mk(0, 32'h001, HSIZE_HALF, 32'h0, 32'h0, HRESP_ERROR));
        vecs.push_back(mk(1, 32'h402, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR));
        vecs.push_back(mk(1, 32'h00A, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR));
        vecs.push_back(mk(0, 32'h008, HSIZE_DWORD, 32'h0, 32'h0, HRESP_ERROR));
        vecs.push_back(mk(0, 32'h008, HSIZE_WORD, 32'h0, 32'h0020_0193, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h00C, HSIZE_WORD, 32'h0, 32'h0000_0013, HRESP_OKAY));
`else
        vecs.push_back(mk(0, 32'h400, HSIZE_WORD, 32'h0, 32'h0000_0093, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h001, HSIZE_HALF, 32'h0, 32'h0000_0093, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h40E, HSIZE_WORD, 32'hCAFE_F00D, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h00C, HSIZE_WORD, 32'h0, 32'hCAFE_F00D, HRESP_OKAY));
        vecs.push_back(mk(1, 32'h008, HSIZE_DWORD, 32'h0102_0304, 32'h0, HRESP_OKAY));
        vecs.push_back(mk(0, 32'h008, HSIZE_WORD, 32'h0, 32'h0102_0304, HRESP_OKAY));
`endif

        hreset    = 1'b1;
        hwdata[0] = '0;
        hwdata[1] = '0;
        drive_idle(0);
        drive_idle(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dut%0d hreadyout", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("reset dut%0d hresp", d), 32'(hresp[d]), 32'(HRESP_OKAY));
            check($sformatf("reset dut%0d hrdata", d), hrdata[d], 32'h0);
        end
        check("num_instr", num_instr[0], 32'd3);
        check("inst_loaded", 32'(inst_loaded[0]), 32'd1);
        hreset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rdata, r_first, r_last, waits);
            check($sformatf("vec%0d wait cycles", i), 32'(waits), 32'(vecs[i].exp_waits));
            check($sformatf("vec%0d first hresp", i), 32'(r_first), 32'(vecs[i].exp_resp));
            check($sformatf("vec%0d last hresp", i), 32'(r_last), 32'(vecs[i].exp_resp));
            if (!vecs[i].wr && vecs[i].exp_resp == HRESP_OKAY)
                check($sformatf("vec%0d hrdata", i), rdata, vecs[i].exp_rdata);
        end

        // Reset held two cycles in the middle of a write's wait states.
        @(negedge clk);
        hsel[0]   = 1'b1;
        htrans[0] = HTRANS_NONSEQ;
        haddr[0]  = 32'h018;
        hwrite[0] = 1'b1;
        hsize[0]  = HSIZE_WORD;
        @(negedge clk);
        drive_idle(0);
        hwdata[0] = 32'h1234_5678;
        check("mid-wait hreadyout", 32'(hreadyout[0]), 32'd0);
        hreset = 1'b1;
        repeat (2) @(negedge clk);
        check("after reset hreadyout", 32'(hreadyout[0]), 32'd1);
        check("after reset hresp", 32'(hresp[0]), 32'(HRESP_OKAY));
        hreset = 1'b0;
        xfer(0, 1'b0, 32'h018, HSIZE_WORD, 32'h0, rdata, r_first, r_last, waits);
        check("dropped write not committed", rdata, 32'h0000_0013);
        xfer(0, 1'b0, 32'h010, HSIZE_WORD, 32'h0, rdata, r_first, r_last, waits);
        check("memory persists through reset", rdata, 32'hBEEF_3344);

        // Zero-wait DUT: pipelined write, read, byte write, read with no idle cycles.
        lows = 0;
        @(negedge clk);
        hsel[1]   = 1'b1;
        htrans[1] = HTRANS_NONSEQ;
        haddr[1]  = 32'h020;
        hwrite[1] = 1'b1;
        hsize[1]  = HSIZE_WORD;
        @(negedge clk);
        lows += (hreadyout[1] !== 1'b1) ? 1 : 0;
        htrans[1] = HTRANS_SEQ;
        hwrite[1] = 1'b0;
        hwdata[1] = 32'h0BAD_F00D;
        @(negedge clk);
        lows += (hreadyout[1] !== 1'b1) ? 1 : 0;
        check("b2b read after write", hrdata[1], 32'h0BAD_F00D);
        check("b2b read hresp", 32'(hresp[1]), 32'(HRESP_OKAY));
        htrans[1] = HTRANS_NONSEQ;
        haddr[1]  = 32'h021;
        hwrite[1] = 1'b1;
        hsize[1]  = HSIZE_BYTE;
        hwdata[1] = 32'h0;
        @(negedge clk);
        lows += (hreadyout[1] !== 1'b1) ? 1 : 0;
        htrans[1] = HTRANS_SEQ;
        haddr[1]  = 32'h020;
        hwrite[1] = 1'b0;
        hsize[1]  = HSIZE_WORD;
        hwdata[1] = 32'h0000_7700;
        @(negedge clk);
        lows += (hreadyout[1] !== 1'b1) ? 1 : 0;
        check("b2b read after byte write", hrdata[1], 32'h0BAD_770D);
        drive_idle(1);
        @(negedge clk);
        lows += (hreadyout[1] !== 1'b1) ? 1 : 0;
        check("b2b hreadyout low cycles", 32'(lows), 32'd0);
        xfer(1, 1'b0, 32'h020, HSIZE_WORD, 32'h0, rdata, r_first, r_last, waits);
        check("zero-wait wait cycles", 32'(waits), 32'd0);
        check("zero-wait readback", rdata, 32'h0BAD_770D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
